// File: rtl/mem_bus_arbiter_if.sv
// Bundle for the memory bus arbiter: the two cache request ports, their acks and responses,
// and the shared memory port. The arbiter takes the slave side; caches and memory take the master side.
interface mem_bus_arbiter_if;
    logic        icache_req_valid;
    logic [31:0] icache_req_addr;
    logic        dcache_req_valid;
    logic [1:0]  dcache_req_cmd;
    logic [31:0] dcache_req_addr;
    logic [63:0] dcache_req_data;
    logic [1:0]  dcache_req_size;

    logic        icache_ack;
    logic [3:0]  icache_ack_tag;
    logic        dcache_ack;
    logic [3:0]  dcache_ack_tag;

    logic        icache_rsp_valid;
    logic [3:0]  icache_rsp_tag;
    logic [63:0] icache_rsp_data;
    logic        dcache_rsp_valid;
    logic [3:0]  dcache_rsp_tag;
    logic [63:0] dcache_rsp_data;

    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [1:0]  proc2mem_size;

    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;

    logic [4:0]  outstanding_cnt;
    logic        err_unknown_tag;

    modport master (
        output icache_req_valid, icache_req_addr,
        output dcache_req_valid, dcache_req_cmd, dcache_req_addr, dcache_req_data, dcache_req_size,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  icache_ack, icache_ack_tag, dcache_ack, dcache_ack_tag,
        input  icache_rsp_valid, icache_rsp_tag, icache_rsp_data,
        input  dcache_rsp_valid, dcache_rsp_tag, dcache_rsp_data,
        input  proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
        input  outstanding_cnt, err_unknown_tag
    );

    modport slave (
        input  icache_req_valid, icache_req_addr,
        input  dcache_req_valid, dcache_req_cmd, dcache_req_addr, dcache_req_data, dcache_req_size,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output icache_ack, icache_ack_tag, dcache_ack, dcache_ack_tag,
        output icache_rsp_valid, icache_rsp_tag, icache_rsp_data,
        output dcache_rsp_valid, dcache_rsp_tag, dcache_rsp_data,
        output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
        output outstanding_cnt, err_unknown_tag
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates icache and dcache onto one tagged memory port with dcache priority and an icache
// anti-starvation override, and routes returned load data back to the owner of each tag.
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int NUM_TAGS     = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    mem_bus_arbiter_if.slave     bus
);

    localparam logic [1:0] BUS_NONE    = 2'd0;
    localparam logic [1:0] BUS_LOAD    = 2'd1;
    localparam logic [1:0] SIZE_DOUBLE = 2'd3;

    logic [2:0]          starve_q, starve_d;
    logic [NUM_TAGS-1:0] tag_valid_q, tag_valid_d;
    logic [NUM_TAGS-1:0] tag_owner_q, tag_owner_d;
    logic [4:0]          outstanding_q, outstanding_d;
    logic                err_q, err_d;

    logic       icache_win, dcache_win;
    logic       mem_accept;
    logic       icache_ack, dcache_ack;
    logic       ack_is_load;
    logic [3:0] ack_tag;
    logic [3:0] rtn_tag;
    logic       rtn_hit, rtn_miss;
    logic       rtn_owner;

    // Grant is purely combinational; reset suppresses it so the bus is idle while resetting.
    always_comb begin
        icache_win = !reset && bus.icache_req_valid &&
                     (!bus.dcache_req_valid || (starve_q == 3'(STARVE_LIMIT)));
        dcache_win = !reset && bus.dcache_req_valid && !icache_win;
        mem_accept = (bus.mem2proc_response != 4'd0);
        icache_ack = icache_win && mem_accept;
        dcache_ack = dcache_win && mem_accept;
        ack_is_load = icache_ack || (dcache_ack && (bus.dcache_req_cmd == BUS_LOAD));
        ack_tag    = bus.mem2proc_response;
    end

    always_comb begin
        rtn_tag   = bus.mem2proc_tag;
        rtn_hit   = (rtn_tag != 4'd0) && tag_valid_q[rtn_tag];
        rtn_miss  = (rtn_tag != 4'd0) && !tag_valid_q[rtn_tag];
        rtn_owner = tag_owner_q[rtn_tag];
    end

    always_comb begin
        bus.proc2mem_command = BUS_NONE;
        bus.proc2mem_addr    = 32'd0;
        bus.proc2mem_data    = 64'd0;
        bus.proc2mem_size    = 2'd0;
        if (icache_win) begin
            bus.proc2mem_command = BUS_LOAD;
            bus.proc2mem_addr    = bus.icache_req_addr;
            bus.proc2mem_size    = SIZE_DOUBLE;
        end else if (dcache_win) begin
            bus.proc2mem_command = bus.dcache_req_cmd;
            bus.proc2mem_addr    = bus.dcache_req_addr;
            bus.proc2mem_data    = bus.dcache_req_data;
            bus.proc2mem_size    = bus.dcache_req_size;
        end
    end

    always_comb begin
        bus.icache_ack     = icache_ack;
        bus.dcache_ack     = dcache_ack;
        bus.icache_ack_tag = icache_ack ? ack_tag : 4'd0;
        bus.dcache_ack_tag = dcache_ack ? ack_tag : 4'd0;

        bus.icache_rsp_valid = !reset && rtn_hit && !rtn_owner;
        bus.dcache_rsp_valid = !reset && rtn_hit && rtn_owner;
        bus.icache_rsp_tag   = bus.icache_rsp_valid ? rtn_tag : 4'd0;
        bus.dcache_rsp_tag   = bus.dcache_rsp_valid ? rtn_tag : 4'd0;
        bus.icache_rsp_data  = bus.icache_rsp_valid ? bus.mem2proc_data : 64'd0;
        bus.dcache_rsp_data  = bus.dcache_rsp_valid ? bus.mem2proc_data : 64'd0;

        bus.outstanding_cnt = outstanding_q;
        bus.err_unknown_tag = err_q;
    end

    // Clear of the returning tag is applied first so a same-cycle reissue of that tag survives.
    always_comb begin
        tag_valid_d = tag_valid_q;
        tag_owner_d = tag_owner_q;
        if (rtn_hit) begin
            tag_valid_d[rtn_tag] = 1'b0;
        end
        if (ack_is_load && (ack_tag != 4'd0)) begin
            tag_valid_d[ack_tag] = 1'b1;
            tag_owner_d[ack_tag] = dcache_ack;
        end

        err_d = err_q || rtn_miss;

        starve_d = starve_q;
        if (icache_ack) begin
            starve_d = 3'd0;
        end else if (bus.icache_req_valid && (starve_q < 3'(STARVE_LIMIT))) begin
            starve_d = starve_q + 3'd1;
        end

        if (reset) begin
            tag_valid_d = '0;
            tag_owner_d = '0;
            err_d       = 1'b0;
            starve_d    = 3'd0;
        end

        outstanding_d = 5'd0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            outstanding_d = outstanding_d + 5'(tag_valid_d[i]);
        end
    end

    always_ff @(posedge clock) begin
        starve_q      <= starve_d;
        tag_valid_q   <= tag_valid_d;
        tag_owner_q   <= tag_owner_d;
        outstanding_q <= outstanding_d;
        err_q         <= err_d;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, consecutive icache losses before icache is forced to win.
REQ-002 Parameter NUM_TAGS, default 16, tag space of the memory port; tag 0 means "none".
REQ-003 clock  input  1  system clock; reset  input  1  reset, synchronous, active-high.
REQ-004 icache_req_valid  input  1  icache read request pending, held until acked.
REQ-005 icache_req_addr  input  32  icache line address.
REQ-006 dcache_req_valid  input  1  dcache request pending, held until acked.
REQ-007 dcache_req_cmd  input  2  BUS_LOAD=1 or BUS_STORE=2.
REQ-008 dcache_req_addr  input  32; dcache_req_data  input  64; dcache_req_size  input  2  dcache request fields.
REQ-009 icache_ack, dcache_ack  output  1 each  request accepted by memory this cycle.
REQ-010 icache_ack_tag, dcache_ack_tag  output  4 each  tag assigned on ack, 0 otherwise.
REQ-011 icache_rsp_valid, dcache_rsp_valid  output  1 each  returned load data for that requester.
REQ-012 icache_rsp_tag, dcache_rsp_tag  output  4 each; icache_rsp_data, dcache_rsp_data  output  64 each.
REQ-013 proc2mem_command  output  2; proc2mem_addr  output  32; proc2mem_data  output  64; proc2mem_size  output  2.
REQ-014 mem2proc_response  input  4; mem2proc_data  input  64; mem2proc_tag  input  4.
REQ-015 outstanding_cnt  output  5  number of load tags in flight.
REQ-016 err_unknown_tag  output  1  sticky: data returned on a tag with no recorded owner.

Function
REQ-017 Combinational grant each cycle: icache wins if only icache valid, or both valid and starve_cnt == STARVE_LIMIT; otherwise dcache wins if valid.
REQ-018 Icache grant drives BUS_LOAD, icache_req_addr, data 0, size DOUBLE (3); dcache grant drives its fields unmodified; no grant drives BUS_NONE (0), addr/data/size 0.
REQ-019 Ack to the granted requester only, asserted iff mem2proc_response != 0 same cycle; ack_tag = mem2proc_response.
REQ-020 Granted but mem2proc_response == 0: no ack, requester holds; grant recomputed next cycle.
REQ-021 starve_cnt (3 bits): increments when icache valid and not acked, saturating at STARVE_LIMIT; clears on icache ack.
REQ-022 Owner table: NUM_TAGS entries {valid, owner}; acked BUS_LOAD sets entry[ack_tag] to valid with owner icache(0)/dcache(1); acked stores are not recorded.
REQ-023 Return: mem2proc_tag != 0 and entry valid -> route to owner's rsp_valid/rsp_tag/rsp_data same cycle, clear entry next edge.
REQ-024 Return on invalid entry: no rsp_valid asserted, data dropped, err_unknown_tag set next edge and held until reset.
REQ-025 Same-cycle return on tag T and new ack on tag T: routing uses pre-edge owner; post-edge entry[T] holds the new owner (set wins over clear).
REQ-026 Entry 0 never written; mem2proc_tag == 0 never routes.
REQ-027 outstanding_cnt = count of valid entries, registered; simultaneous set and clear of different tags nets zero.
REQ-028 rsp_data outputs equal mem2proc_data when that requester's rsp_valid is high, 0 otherwise.

Reset
REQ-029 On reset: owner table all invalid, starve_cnt 0, outstanding_cnt 0, err_unknown_tag 0.
REQ-030 During reset all acks and rsp_valids 0, proc2mem_command BUS_NONE; in-flight loads are abandoned, later returns follow REQ-024.

Verification
REQ-031 Both valid, response 3 -> dcache_ack=1 tag 3, icache_ack=0, starve_cnt=1; entry 3 owner dcache if load.
REQ-032 Both valid 4 cycles, memory acks each -> 5th cycle icache_ack=1, starve_cnt returns to 0.
REQ-033 Icache load acked tag 5, later mem2proc_tag=5 data 0xDEADBEEF_01234567 -> icache_rsp_valid=1 tag 5 with that data, outstanding_cnt 1->0.
REQ-034 Dcache store acked tag 7, then mem2proc_tag=7 -> no rsp_valid, err_unknown_tag=1 sticky.
REQ-035 Tag 2 returns to dcache while icache acked on tag 2 same cycle -> dcache_rsp_valid=1; next return on tag 2 goes to icache; outstanding_cnt unchanged.
REQ-036 Three loads outstanding, reset pulse 1 cycle -> outstanding_cnt 0, command BUS_NONE during reset; later return on old tag sets err_unknown_tag.
